data_mem_unit: RTL and testbench

DATA_MEM_UNIT -- requirements
Module: data_mem_unit

---
 rtl/data_mem_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_data_mem_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Data memory unit for the stage-3 load/store path.
// Holds the data RAM plus three memory-mapped registers (GPIO, CYCLE, STATUS).
// Loads are combinational with zero latency; stores commit on the rising edge.
// Any illegal access is refused and latches a sticky fault flag.
module data_mem_unit #(
  parameter int RAM_WORDS = 256
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] MEM_addr,
  input  logic [31:0] MEM_WR_out,
  input  logic [2:0]  MEM_type,
  input  logic        MEM_rd_en,
  input  logic        MEM_wr_en,
  output logic [31:0] MEM_data,
  output logic [31:0] GPIO_out,
  output logic        MEM_fault
);

  localparam int IDX_W = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  // Register locations expressed as word addresses (byte address >> 2)
  localparam logic [29:0] RAM_LIMIT   = 30'(RAM_WORDS);
  localparam logic [29:0] GPIO_WORD   = 30'h0000_0400;
  localparam logic [29:0] CYCLE_WORD  = 30'h0000_0401;
  localparam logic [29:0] STATUS_WORD = 30'h0000_0402;

  // RISC-V funct3 access sizes
  localparam logic [2:0] TYPE_B  = 3'b000;
  localparam logic [2:0] TYPE_H  = 3'b001;
  localparam logic [2:0] TYPE_W  = 3'b010;
  localparam logic [2:0] TYPE_BU = 3'b100;
  localparam logic [2:0] TYPE_HU = 3'b101;

  logic [31:0]      ram [RAM_WORDS];
  logic [31:0]      gpio_reg;
  logic [31:0]      cycle_count;
  logic             fault_reg;

  logic [29:0]      word_addr;
  logic [1:0]       lane;
  logic [IDX_W-1:0] ram_idx;

  logic             hit_gpio;
  logic             hit_cycle;
  logic             hit_status;
  logic             hit_ram;
  logic             unmapped;

  logic             size_byte;
  logic             size_half;
  logic             size_word;
  logic             load_type_ok;
  logic             store_type_ok;

  logic             misaligned;
  logic             type_bad;
  logic             illegal;
  logic             load_ok;
  logic             store_ok;

  logic [3:0]       byte_en;
  logic [31:0]      wr_data;
  logic [31:0]      rd_word;
  logic [31:0]      load_result;
  logic             status_clear;

  assign word_addr = MEM_addr[31:2];
  assign lane      = MEM_addr[1:0];
  assign ram_idx   = MEM_addr[IDX_W+1:2];

  // Registers take priority over RAM so a very deep RAM cannot shadow them
  assign hit_gpio   = (word_addr == GPIO_WORD);
  assign hit_cycle  = (word_addr == CYCLE_WORD);
  assign hit_status = (word_addr == STATUS_WORD);
  assign hit_ram    = (word_addr < RAM_LIMIT) && !hit_gpio && !hit_cycle && !hit_status;
  assign unmapped   = !(hit_ram || hit_gpio || hit_cycle || hit_status);

  // Decode access width and which directions each funct3 code is valid for
  always_comb begin
    size_byte     = 1'b0;
    size_half     = 1'b0;
    size_word     = 1'b0;
    load_type_ok  = 1'b0;
    store_type_ok = 1'b0;
    case (MEM_type)
      TYPE_B: begin
        size_byte     = 1'b1;
        load_type_ok  = 1'b1;
        store_type_ok = 1'b1;
      end
      TYPE_H: begin
        size_half     = 1'b1;
        load_type_ok  = 1'b1;
        store_type_ok = 1'b1;
      end
      TYPE_W: begin
        size_word     = 1'b1;
        load_type_ok  = 1'b1;
        store_type_ok = 1'b1;
      end
      TYPE_BU: begin
        size_byte    = 1'b1;
        load_type_ok = 1'b1;
      end
      TYPE_HU: begin
        size_half    = 1'b1;
        load_type_ok = 1'b1;
      end
      default: begin
        size_byte = 1'b0;
      end
    endcase
  end

  assign misaligned = (size_half && lane[0]) || (size_word && (lane != 2'b00));
  assign type_bad   = (MEM_rd_en && !load_type_ok) || (MEM_wr_en && !store_type_ok);

  // Only an actual request can be illegal; an idle bus never faults
  assign illegal = (MEM_rd_en || MEM_wr_en) &&
                   (type_bad || misaligned || unmapped ||
                    (MEM_rd_en && MEM_wr_en) || (MEM_wr_en && hit_cycle));

  assign load_ok  = MEM_rd_en && !illegal;
  assign store_ok = MEM_wr_en && !illegal;

  // Byte-lane enables and lane-replicated store data
  always_comb begin
    byte_en = 4'b0000;
    wr_data = MEM_WR_out;
    if (size_byte) begin
      byte_en = 4'b0001 << lane;
      wr_data = {4{MEM_WR_out[7:0]}};
    end else if (size_half) begin
      byte_en = lane[1] ? 4'b1100 : 4'b0011;
      wr_data = {2{MEM_WR_out[15:0]}};
    end else if (size_word) begin
      byte_en = 4'b1111;
      wr_data = MEM_WR_out;
    end
  end

  // Select the addressed word; CYCLE reads the count held before this edge
  always_comb begin
    rd_word = 32'h0000_0000;
    if (hit_gpio) begin
      rd_word = gpio_reg;
    end else if (hit_cycle) begin
      rd_word = cycle_count;
    end else if (hit_status) begin
      rd_word = {31'h0000_0000, fault_reg};
    end else if (hit_ram) begin
      rd_word = ram[ram_idx];
    end
  end

  // Extract the byte or half and right-justify it with zero fill
  always_comb begin
    load_result = rd_word;
    if (size_byte) begin
      case (lane)
        2'd0:    load_result = {24'h000000, rd_word[7:0]};
        2'd1:    load_result = {24'h000000, rd_word[15:8]};
        2'd2:    load_result = {24'h000000, rd_word[23:16]};
        default: load_result = {24'h000000, rd_word[31:24]};
      endcase
    end else if (size_half) begin
      load_result = lane[1] ? {16'h0000, rd_word[31:16]} : {16'h0000, rd_word[15:0]};
    end
  end

  assign MEM_data = load_ok ? load_result : 32'h0000_0000;

  // RAM byte-lane writes; RAM has no reset and refuses stores while Reset is low
  always_ff @(posedge CLK) begin
    if (store_ok && hit_ram && Reset) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          ram[ram_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // GPIO output register with the same lane merging as RAM
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      gpio_reg <= 32'h0000_0000;
    end else if (store_ok && hit_gpio) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          gpio_reg[8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Free-running cycle counter, wraps naturally at 32 bits
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cycle_count <= 32'h0000_0000;
    end else begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  assign status_clear = store_ok && hit_status && byte_en[0] && wr_data[0];

  // Sticky fault flag: set wins over a write-1-to-clear in the same cycle
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      fault_reg <= 1'b0;
    end else if (illegal) begin
      fault_reg <= 1'b1;
    end else if (status_clear) begin
      fault_reg <= 1'b0;
    end
  end

  assign GPIO_out  = gpio_reg;
  assign MEM_fault = fault_reg;

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit.
// Inputs change on the falling edge; load data is queued as an expectation
// when the request is driven and compared once the combinational path settles.
module tb_data_mem_unit;

  localparam logic [2:0] T_B  = 3'b000;
  localparam logic [2:0] T_H  = 3'b001;
  localparam logic [2:0] T_W  = 3'b010;
  localparam logic [2:0] T_BU = 3'b100;
  localparam logic [2:0] T_HU = 3'b101;

  logic        CLK;
  logic        Reset;
  logic [31:0] MEM_addr;
  logic [31:0] MEM_WR_out;
  logic [2:0]  MEM_type;
  logic        MEM_rd_en;
  logic        MEM_wr_en;
  logic [31:0] MEM_data;
  logic [31:0] GPIO_out;
  logic        MEM_fault;

  int vectors_applied = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [31:0] expected;
  } sb_entry_t;

  sb_entry_t sb_queue[$];

  data_mem_unit #(.RAM_WORDS(256)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .MEM_addr  (MEM_addr),
    .MEM_WR_out(MEM_WR_out),
    .MEM_type  (MEM_type),
    .MEM_rd_en (MEM_rd_en),
    .MEM_wr_en (MEM_wr_en),
    .MEM_data  (MEM_data),
    .GPIO_out  (GPIO_out),
    .MEM_fault (MEM_fault)
  );

  // 10-unit clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Guard against a hung run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors_applied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic drainScoreboard();
    sb_entry_t e;
    while (sb_queue.size() > 0) begin
      e = sb_queue.pop_front();
      checkOutput(e.tag, MEM_data, e.expected);
    end
  endtask

  // Drive one request in the current cycle and, if wanted, queue its expected load data
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [2:0] typ, input logic [31:0] wdata,
                               input logic has_exp, input logic [31:0] expected, input string tag);
    sb_entry_t e;
    MEM_rd_en  = rd;
    MEM_wr_en  = wr;
    MEM_addr   = addr;
    MEM_type   = typ;
    MEM_WR_out = wdata;
    if (has_exp) begin
      e.tag      = tag;
      e.expected = expected;
      sb_queue.push_back(e);
    end
    #2;
    drainScoreboard();
  endtask

  task automatic doLoad(input logic [31:0] addr, input logic [2:0] typ, input logic [31:0] expected, input string tag);
    @(negedge CLK);
    applyStimulus(1'b1, 1'b0, addr, typ, 32'h0, 1'b1, expected, tag);
  endtask

  task automatic doStore(input logic [31:0] addr, input logic [2:0] typ, input logic [31:0] wdata);
    @(negedge CLK);
    applyStimulus(1'b0, 1'b1, addr, typ, wdata, 1'b0, 32'h0, "");
  endtask

  task automatic doIdle(input string tag);
    @(negedge CLK);
    applyStimulus(1'b0, 1'b0, 32'h0000_0010, T_W, 32'h0, 1'b1, 32'h0, tag);
  endtask

  task automatic checkFault(input logic expected, input string tag);
    checkOutput(tag, {31'h0, MEM_fault}, {31'h0, expected});
  endtask

  initial begin
    Reset      = 1'b0;
    MEM_addr   = 32'h0;
    MEM_WR_out = 32'h0;
    MEM_type   = T_W;
    MEM_rd_en  = 1'b0;
    MEM_wr_en  = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    checkOutput("reset_gpio", GPIO_out, 32'h0);
    checkFault(1'b0, "reset_fault");
    checkOutput("reset_data", MEM_data, 32'h0);

    // Counter reads 0 in the cycle reset is released, then counts each edge
    @(negedge CLK);
    Reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h0000_1004, T_W, 32'h0, 1'b1, 32'd0, "cyc_first");
    for (int i = 1; i <= 10; i++) begin
      doLoad(32'h0000_1004, T_W, 32'(i), "cyc_count");
    end

    // Wrap from all-ones to zero
    @(negedge CLK);
    force dut.cycle_count = 32'hFFFF_FFFF;
    applyStimulus(1'b1, 1'b0, 32'h0000_1004, T_W, 32'h0, 1'b1, 32'hFFFF_FFFF, "cyc_forced");
    release dut.cycle_count;
    doLoad(32'h0000_1004, T_W, 32'h0, "cyc_wrap");
    doStore(32'h0000_1004, T_W, 32'h0000_0055);
    doLoad(32'h0000_1004, T_W, 32'd2, "cyc_after_sw");
    checkFault(1'b1, "fault_cyc_store");
    doStore(32'h0000_1008, T_W, 32'h1);
    doIdle("idle_data");
    checkFault(1'b0, "fault_cleared_1");

    // Word round trip and sub-word loads
    doStore(32'h10, T_W, 32'hDEAD_BEEF);
    doLoad(32'h10, T_W,  32'hDEAD_BEEF, "lw_0x10");
    doLoad(32'h13, T_BU, 32'h0000_00DE, "lbu_0x13");
    doLoad(32'h12, T_H,  32'h0000_DEAD, "lh_0x12");
    doLoad(32'h10, T_B,  32'h0000_00EF, "lb_0x10");

    // Lane merge
    doStore(32'h20, T_W, 32'h1122_3344);
    doStore(32'h21, T_B, 32'h0000_00AA);
    doLoad(32'h20, T_W, 32'h1122_AA44, "merge_sb");
    doStore(32'h22, T_H, 32'h0000_5566);
    doLoad(32'h20, T_W,  32'h5566_AA44, "merge_sh");
    doLoad(32'h20, T_HU, 32'h0000_AA44, "lhu_0x20");

    // Misalignment and other illegal accesses
    doLoad(32'h22, T_W, 32'h0, "lw_misaligned");
    doIdle("idle_data");
    checkFault(1'b1, "fault_misaligned");
    doLoad(32'h1008, T_W, 32'h1, "status_read");
    doLoad(32'h20, T_W, 32'h5566_AA44, "ram_unchanged");
    doStore(32'h1008, T_W, 32'h2);
    doIdle("idle_data");
    checkFault(1'b1, "status_bit1_no_clear");
    doStore(32'h1008, T_W, 32'h1);
    doIdle("idle_data");
    checkFault(1'b0, "fault_cleared_2");
    doStore(32'h21, T_H, 32'h0000_BEEF);
    doStore(32'h20, T_BU, 32'h0000_00FF);
    doLoad(32'h20, T_W, 32'h5566_AA44, "illegal_st_no_write");
    checkFault(1'b1, "fault_illegal_st");
    doLoad(32'h800, T_W, 32'h0, "unmapped");
    doLoad(32'h20, 3'b011, 32'h0, "bad_type");
    doStore(32'h1008, T_B, 32'h1);
    doIdle("idle_data");
    checkFault(1'b0, "fault_cleared_sb");

    // Same-cycle hazard: load sees old word, store lands at the edge
    doStore(32'h30, T_W, 32'hAAAA_5555);
    @(negedge CLK);
    applyStimulus(1'b1, 1'b0, 32'h30, T_W, 32'h0, 1'b1, 32'hAAAA_5555, "hazard_old");
    MEM_rd_en  = 1'b0;
    MEM_wr_en  = 1'b1;
    MEM_WR_out = 32'h1234_5678;
    doLoad(32'h30, T_W, 32'h1234_5678, "hazard_new");
    @(negedge CLK);
    applyStimulus(1'b1, 1'b1, 32'h30, T_W, 32'hFFFF_FFFF, 1'b1, 32'h0, "rdwr_both");
    doLoad(32'h30, T_W, 32'h1234_5678, "rdwr_no_write");
    checkFault(1'b1, "fault_rdwr");
    doStore(32'h1008, T_W, 32'h1);

    // GPIO with lane merging
    doStore(32'h1000, T_W, 32'hCAFE_F00D);
    doIdle("idle_data");
    checkOutput("gpio_sw", GPIO_out, 32'hCAFE_F00D);
    doStore(32'h1001, T_B, 32'h0000_0077);
    doLoad(32'h1000, T_W, 32'hCAFE_770D, "gpio_sb_read");
    checkOutput("gpio_sb", GPIO_out, 32'hCAFE_770D);
    doStore(32'h1001, T_B, 32'h0000_00F0);
    doLoad(32'h22, T_W, 32'h0, "lw_misaligned_2");
    doIdle("idle_data");
    checkFault(1'b1, "fault_before_reset");
    checkOutput("gpio_before_reset", GPIO_out, 32'hCAFE_F00D);

    // Reset mid-operation, with a store held across an edge during reset
    @(negedge CLK);
    applyStimulus(1'b0, 1'b1, 32'h10, T_W, 32'h0, 1'b0, 32'h0, "");
    Reset = 1'b0;
    #1;
    checkOutput("gpio_async_reset", GPIO_out, 32'h0);
    checkFault(1'b0, "fault_async_reset");
    @(negedge CLK);
    Reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h10, T_W, 32'h0, 1'b1, 32'hDEAD_BEEF, "ram_survives_reset");
    doLoad(32'h1004, T_W, 32'd1, "cyc_after_reset");
    checkOutput("gpio_after_reset", GPIO_out, 32'h0);

    doIdle("idle_data");
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
